kgp_multicycle_cu: RTL and testbench

//  Multi-cycle control unit for KGPRisc, successor to the single-cycle ControlUnit decoder.

---
 rtl/kgp_cu_pkg.sv | 24 ++
 rtl/kgp_branch_cond.sv | 27 ++
 rtl/kgp_multicycle_cu.sv | 126 ++++++++++++
 tb/tb_kgp_multicycle_cu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/kgp_cu_pkg.sv
// kgp_cu_pkg: shared FSM states, opcode constants and pc_src codes for the KGPRisc multi-cycle control unit
package kgp_cu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT_S} state_t;
  localparam logic [4:0] OP_LD   = 5'd16;
  localparam logic [4:0] OP_ST   = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_BZ   = 5'd20;
  localparam logic [4:0] OP_BNZ  = 5'd21;
  localparam logic [4:0] OP_BCY  = 5'd22;
  localparam logic [4:0] OP_BNCY = 5'd23;
  localparam logic [4:0] OP_BS   = 5'd24;
  localparam logic [4:0] OP_BNS  = 5'd25;
  localparam logic [4:0] OP_BV   = 5'd26;
  localparam logic [4:0] OP_BNV  = 5'd27;
  localparam logic [4:0] OP_CALL = 5'd28;
  localparam logic [4:0] OP_RET  = 5'd29;
  localparam logic [4:0] OP_NOP  = 5'd30;
  localparam logic [4:0] OP_HALT = 5'd31;
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_IMM  = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;
  localparam logic [1:0] PC_LINK = 2'b11;
endpackage

// File: rtl/kgp_branch_cond.sv
// kgp_branch_cond: resolves whether a control-transfer opcode redirects the PC given the ALU flags
module kgp_branch_cond
  import kgp_cu_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic       zero_i,
  input  logic       carry_i,
  input  logic       sign_i,
  input  logic       overflow_i,
  output logic       taken_o
);
  // unconditional transfers always redirect; conditional ones test one flag, odd codes negated
  always_comb begin
    case (op_i)
      OP_B, OP_BR, OP_CALL, OP_RET: taken_o = 1'b1;
      OP_BZ:   taken_o = zero_i;
      OP_BNZ:  taken_o = !zero_i;
      OP_BCY:  taken_o = carry_i;
      OP_BNCY: taken_o = !carry_i;
      OP_BS:   taken_o = sign_i;
      OP_BNS:  taken_o = !sign_i;
      OP_BV:   taken_o = overflow_i;
      OP_BNV:  taken_o = !overflow_i;
      default: taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/kgp_multicycle_cu.sv
// kgp_multicycle_cu: multi-cycle KGPRisc control FSM; define KGP_CU_ILLEGAL_TRAP_EN to halt on opcodes >= 32 and expose illegal
module kgp_multicycle_cu
  import kgp_cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                carry,
  input  logic                sign,
  input  logic                overflow,
  input  logic                dmem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                link_write,
  output logic                halted,
  output logic                bus_err
`ifdef KGP_CU_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
`ifdef KGP_CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  logic [4:0]          op;
  logic                bad_op, trap, taken, is_alu, is_ld, is_st;
  assign bad_op = |opcode[OPCODE_W-1:5];
  assign trap   = TRAP_EN && state_q == DECODE && bad_op;
  assign op     = |op_q[OPCODE_W-1:5] ? OP_NOP : op_q[4:0];
  assign is_alu = op < OP_LD;
  assign is_ld  = op == OP_LD;
  assign is_st  = op == OP_ST;
  kgp_branch_cond u_cond (
    .op_i      (op),
    .zero_i    (zero),
    .carry_i   (carry),
    .sign_i    (sign),
    .overflow_i(overflow),
    .taken_o   (taken)
  );
  // state, latched opcode, dmem wait counter and sticky bus error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end
  // sequencing; the counter is zeroed on the way into MEM and the last allowed cycle still accepts dmem_ready
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        op_d    = opcode;
        state_d = trap ? HALT_S : EXEC;
      end
      EXEC: begin
        wait_d  = '0;
        state_d = is_alu ? WB : (is_ld || is_st) ? MEM : op == OP_HALT ? HALT_S : FETCH;
      end
      MEM: begin
        wait_d = wait_q + 1'b1;
        if (dmem_ready) state_d = is_ld ? WB : FETCH;
        else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d   = HALT_S;
          bus_err_d = 1'b1;
        end
      end
      WB: state_d = FETCH;
      default: state_d = HALT_S;
    endcase
  end
  // Moore strobes from state and latched opcode; only the taken flag reaches in combinationally during EXEC
  always_comb begin
    ir_write   = state_q == FETCH;
    pc_write   = state_q == FETCH || (state_q == EXEC && taken);
    pc_src     = state_q == EXEC && taken ? (op == OP_BR ? PC_REG : op == OP_RET ? PC_LINK : PC_IMM) : PC_INC;
    alu_op     = state_q == EXEC && is_alu ? op[ALUOP_W-1:0] : '0;
    alu_src    = state_q == EXEC && ((is_alu && op[3]) || is_ld || is_st);
    mem_read   = state_q == MEM && is_ld;
    mem_write  = state_q == MEM && is_st;
    mem_to_reg = state_q == WB && is_ld;
    reg_write  = state_q == WB;
    link_write = state_q == EXEC && op == OP_CALL;
    halted     = state_q == HALT_S;
    bus_err    = bus_err_q;
  end
`ifdef KGP_CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  // sticky record of an illegal opcode seen in DECODE
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`endif
endmodule

// File: tb/tb_kgp_multicycle_cu.sv
// tb_kgp_multicycle_cu: directed self-checking bench for the KGPRisc multi-cycle control unit
module tb_kgp_multicycle_cu;
`ifdef KGP_CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0;
  logic zero = 1'b0, carry = 1'b0, sign = 1'b0, overflow = 1'b0, dmem_ready = 1'b0;
  logic ir_write, pc_write, alu_src, mem_read, mem_write, mem_to_reg, reg_write, link_write, halted, bus_err;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
`ifdef KGP_CU_ILLEGAL_TRAP_EN
  logic illegal;
`endif
  logic [14:0] outs;
  logic [14:0] F, Z, RW, WBL, MR, MW, AS, H, HB, TK, BRV, CALLV, RETV, e2, e3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  kgp_multicycle_cu dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .carry(carry), .sign(sign),
    .overflow(overflow), .dmem_ready(dmem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .link_write(link_write), .halted(halted), .bus_err(bus_err)
`ifdef KGP_CU_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
  assign outs = {ir_write, pc_write, pc_src, alu_op, alu_src, mem_read, mem_write,
                 mem_to_reg, reg_write, link_write, halted, bus_err};
  function automatic logic [14:0] mk(input int ir, pw, ps, ao, as, mr, mw, mtr, rw, lw, h, be);
    return {1'(ir), 1'(pw), 2'(ps), 3'(ao), 1'(as), 1'(mr), 1'(mw), 1'(mtr), 1'(rw), 1'(lw), 1'(h), 1'(be)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input string tag, input logic [14:0] e);
    chk(tag, 32'(outs), 32'(e));
    tick;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  function automatic void sweep_exp(input int o, output logic [14:0] x2, output logic [14:0] x3);
    x3 = F;
    if (o < 16) begin
      x2 = mk(0, 0, 0, o % 8, o / 8, 0, 0, 0, 0, 0, 0, 0);
      x3 = RW;
    end else if (o == 16) begin
      x2 = AS;
      x3 = MR;
    end else if (o == 17) begin
      x2 = AS;
      x3 = MW;
    end else if (o == 18 || o == 20 || o == 23 || o == 24 || o == 27) x2 = TK;
    else if (o == 19) x2 = BRV;
    else if (o == 28) x2 = CALLV;
    else if (o == 29) x2 = RETV;
    else if (o == 31) begin
      x2 = Z;
      x3 = H;
    end else if (o >= 32 && TRAP) begin
      x2 = H;
      x3 = H;
    end else x2 = Z;
  endfunction
  initial begin
    F     = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Z     = '0;
    RW    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    WBL   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    MR    = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    MW    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    AS    = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    H     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    HB    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    TK    = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    BRV   = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    CALLV = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    RETV  = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset;
    chk("reset", 32'(outs), 32'(F));
    opcode = 6'd0; dmem_ready = 1'b1;
    cyc("add_c0", F); cyc("add_c1", Z); cyc("add_c2", Z); cyc("add_c3", RW);
    opcode = 6'd13;
    cyc("addi_c0", F); cyc("addi_c1", Z); cyc("addi_c2", mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0)); cyc("addi_c3", RW);
    opcode = 6'd6;
    cyc("alu6_c0", F); cyc("alu6_c1", Z); cyc("alu6_c2", mk(0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0)); cyc("alu6_c3", RW);
    opcode = 6'd16; dmem_ready = 1'b0;
    cyc("ld_c0", F); cyc("ld_c1", Z); cyc("ld_exec", AS);
    cyc("ld_w1", MR); cyc("ld_w2", MR); cyc("ld_w3", MR);
    dmem_ready = 1'b1;
    cyc("ld_rdy", MR);
    dmem_ready = 1'b0;
    cyc("ld_wb", WBL);
    opcode = 6'd17; dmem_ready = 1'b1;
    cyc("st_c0", F); cyc("st_c1", Z); cyc("st_exec", AS); cyc("st_mem", MW);
    opcode = 6'd20; zero = 1'b1;
    cyc("bz1_c0", F); cyc("bz1_c1", Z); cyc("bz1_exec", TK);
    zero = 1'b0;
    cyc("bz0_c0", F); cyc("bz0_c1", Z); cyc("bz0_exec", Z);
    opcode = 6'd23; carry = 1'b1;
    cyc("bncy_c0", F); cyc("bncy_c1", Z); cyc("bncy_exec", Z);
    opcode = 6'd26; overflow = 1'b1;
    cyc("bv_c0", F); cyc("bv_c1", Z); cyc("bv_exec", TK);
    opcode = 6'd19;
    cyc("br_c0", F); cyc("br_c1", Z); cyc("br_exec", BRV);
    opcode = 6'd28;
    cyc("call_c0", F); cyc("call_c1", Z); cyc("call_exec", CALLV);
    opcode = 6'd29;
    cyc("ret_c0", F); cyc("ret_c1", Z); cyc("ret_exec", RETV);
    opcode = 6'd30;
    cyc("nop_c0", F); cyc("nop_c1", Z); cyc("nop_exec", Z);
    opcode = 6'd5;
    cyc("hold_c0", F); cyc("hold_c1", Z);
    opcode = 6'd16;
    cyc("hold_exec", mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0)); cyc("hold_wb", RW);
    chk("hold_next", 32'(outs), 32'(F));
    dmem_ready = 1'b0;
    cyc("ld14_c0", F); cyc("ld14_c1", Z); cyc("ld14_exec", AS);
    for (int k = 0; k < 14; k++) cyc($sformatf("ld14_w%0d", k), MR);
    dmem_ready = 1'b1;
    cyc("ld14_last", MR);
    dmem_ready = 1'b0;
    cyc("ld14_wb", WBL);
    chk("ld14_fetch", 32'(outs), 32'(F));
    cyc("mid_c0", F); cyc("mid_c1", Z); cyc("mid_exec", AS); cyc("mid_m1", MR); cyc("mid_m2", MR);
    do_reset;
    chk("mid_rst", 32'(outs), 32'(F));
    opcode = 6'd17;
    cyc("to_c0", F); cyc("to_c1", Z); cyc("to_exec", AS);
    for (int k = 0; k < 15; k++) cyc($sformatf("to_m%0d", k), MW);
    opcode = 6'd0;
    cyc("to_halt", HB); cyc("to_halt2", HB);
    do_reset;
    chk("to_rst", 32'(outs), 32'(F));
    opcode = 6'd31;
    cyc("halt_c0", F); cyc("halt_c1", Z); cyc("halt_exec", Z); cyc("halt_s", H); cyc("halt_s2", H);
    zero = 1'b1; carry = 1'b0; sign = 1'b1; overflow = 1'b0; dmem_ready = 1'b1;
    for (int o = 0; o < 64; o++) begin
      do_reset;
      opcode = 6'(o);
      sweep_exp(o, e2, e3);
      cyc($sformatf("sw%0d_c0", o), F);
      cyc($sformatf("sw%0d_c1", o), Z);
      cyc($sformatf("sw%0d_c2", o), e2);
      chk($sformatf("sw%0d_c3", o), 32'(outs), 32'(e3));
`ifdef KGP_CU_ILLEGAL_TRAP_EN
      chk($sformatf("sw%0d_illegal", o), 32'(illegal), 32'(o >= 32));
`endif
    end
    do_reset;
`ifdef KGP_CU_ILLEGAL_TRAP_EN
    chk("illegal_rst", 32'(illegal), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
